lc3_int_ctrl: RTL and testbench
===============================

// Module: lc3_int_ctrl
// PURPOSE
//  Parametrised multi-source interrupt controller for the LC-3 core; replaces the datapath's single
//  IRQ/INTP/INTV latch. Latches per-source request edges, arbitrates by programmable priority, and
//  offers one interrupt at a time to control. Offers a source only if its priority beats PSR[10:8].
//  Returns vector address and new priority through an offer/ack handshake. Sits beside the datapath.
// PARAMETERS
//  NUM_SRC   4        number of interrupt sources (1..16)
//  PRIO_W    3        priority width (matches PSR[10:8])
//  VEC_W     8        per-source vector width
//  VEC_BASE  16'h0100 vector table base, OR'd with the selected vector
//  IDX_W     $clog2(NUM_SRC) (min 1)  source index width (derived)
// PORTS
//  clk       in   1               system clock; everything on rising edge
//  rst       in   1               asynchronous, active-low reset (0 = reset)
//  irq       in   NUM_SRC         request lines; rising edge = one request
//  src_en    in   NUM_SRC         per-source enable mask
//  src_prio  in   NUM_SRC*PRIO_W  priority of source i at [i*PRIO_W +: PRIO_W]
//  src_vec   in   NUM_SRC*VEC_W   vector of source i at [i*VEC_W +: VEC_W]
//  psr_prio  in   PRIO_W          current processor priority (PSR[10:8])
//  int_ack   in   1               control accepts the offered interrupt
//  clr_en    in   1               software clear strobe
//  clr_idx   in   IDX_W           source to clear
//  int_o     out  1               interrupt offer to control (INT)
//  int_vec   out  16              VEC_BASE | src_vec[int_src], zero-extended
//  int_prio  out  PRIO_W          priority to load into PSR on accept
//  int_src   out  IDX_W           index of offered source
//  pend      out  NUM_SRC         pending flags
//  ovf       out  NUM_SRC         sticky: edge arrived while already pending
// BEHAVIOUR
//  Reset: pend=0, ovf=0, irq_q=0, state=IDLE; int_o=0, int_vec=0, int_prio=0, int_src=0.
//  Edge detect: edge[i] = irq[i] & ~irq_q[i]. irq_q resets to 0, so irq high at reset release = 1 edge.
//  Pending: edge sets pend[i] next cycle. Edge while pend[i]=1 sets ovf[i]; pend stays 1.
//  Clear: clr_en clears pend[clr_idx] and ovf[clr_idx]; clr_idx>=NUM_SRC ignored.
//  Same-cycle clear/ack and edge on one source: edge wins, pend stays 1, ovf unchanged.
//  Eligible[i] = pend[i] & src_en[i] & (src_prio[i] > psr_prio), unsigned compare.
//  Winner = highest src_prio among eligible; ties go to the lowest index.
//  FSM states: IDLE, OFFER, RECOVER.
//   IDLE: if any eligible, register winner idx/vec/prio into int_src/int_vec/int_prio and go to OFFER.
//     First int_o is one cycle after pend is visible (arbitration latency 1).
//   OFFER: int_o=1; int_src/int_vec/int_prio stay frozen, no preemption by higher arrivals.
//     int_ack=1: clear pend[int_src] (subject to edge-wins rule), go to RECOVER.
//     No ack and offered source no longer eligible (psr_prio raised, src_en dropped, or software
//     clear): withdraw, int_o=0 next cycle, go to IDLE. Ack has priority over withdrawal.
//   RECOVER: int_o=0 for exactly one cycle so control sees the updated psr_prio; then go to IDLE.
//  int_o is registered (asserted in OFFER only); int_ack outside OFFER is ignored.
//  Outputs keep their last values when not in OFFER; only int_o is qualified.
//  Reset mid-offer: int_o drops immediately (async), pending state lost.
// TESTING
//  1 src2 prio5 vec 8'h80, psr_prio=0, pulse irq[2] -> pend[2] next cycle; int_o 1 cycle later,
//    int_vec=16'h0180, int_prio=5, int_src=2; ack -> pend[2]=0, int_o low >=1 cycle.
//  2 src1 prio3 and src3 prio6 same cycle -> src3 offered first; after ack+RECOVER src1 (vec check).
//  3 src0,src1 both prio4 -> src0 first; psr_prio=4 with src prio4 pending -> int_o stays 0.
//  4 during OFFER of src1 (prio3) set psr_prio=3, no ack -> int_o=0 next cycle, pend[1] still 1.
//  5 second irq[2] edge while pend[2]=1 -> ovf[2]=1; ack and new edge same cycle -> pend[2] stays 1.
//  6 assert rst (0) while int_o=1 -> int_o, pend, ovf all 0 at once; irq held high -> one new pend.

Source files
------------

// File: rtl/lc3_int_ctrl.sv
// Multi-source interrupt controller for the LC-3: per-source edge latching,
// priority arbitration against PSR priority, and an offer/ack handshake to control.
module lc3_int_ctrl #(
    parameter int          NUM_SRC  = 4,
    parameter int          PRIO_W   = 3,
    parameter int          VEC_W    = 8,
    parameter logic [15:0] VEC_BASE = 16'h0100,
    parameter int          IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [NUM_SRC*VEC_W-1:0]  src_vec,
    input  logic [PRIO_W-1:0]         psr_prio,
    input  logic                      int_ack,
    input  logic                      clr_en,
    input  logic [IDX_W-1:0]          clr_idx,
    output logic                      int_o,
    output logic [15:0]               int_vec,
    output logic [PRIO_W-1:0]         int_prio,
    output logic [IDX_W-1:0]          int_src,
    output logic [NUM_SRC-1:0]        pend,
    output logic [NUM_SRC-1:0]        ovf
);

    typedef enum logic [1:0] {IDLE, OFFER, RECOVER} state_t;

    state_t               state;
    logic [NUM_SRC-1:0]   irq_q;
    logic [NUM_SRC-1:0]   edge_det;
    logic [NUM_SRC-1:0]   clr_hit;
    logic [NUM_SRC-1:0]   ack_hit;
    logic [NUM_SRC-1:0]   elig;
    logic [NUM_SRC-1:0]   pend_next;
    logic [NUM_SRC-1:0]   ovf_next;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [PRIO_W-1:0]    win_prio;
    logic [VEC_W-1:0]     win_vec;
    logic [15:0]          win_vec_ext;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign edge_det[gi] = irq[gi] & ~irq_q[gi];
            // Out-of-range clear indices simply match no source.
            assign clr_hit[gi]  = clr_en && (int'(clr_idx) == gi);
            assign ack_hit[gi]  = (state == OFFER) && int_ack && (int'(int_src) == gi);
            assign elig[gi]     = pend[gi] & src_en[gi] &
                                  (src_prio[gi*PRIO_W +: PRIO_W] > psr_prio);

            // A new edge always wins over a same-cycle clear or ack.
            always_comb begin
                pend_next[gi] = pend[gi];
                ovf_next[gi]  = ovf[gi];
                if (edge_det[gi]) begin
                    pend_next[gi] = 1'b1;
                    if (pend[gi] && !clr_hit[gi] && !ack_hit[gi])
                        ovf_next[gi] = 1'b1;
                end else if (clr_hit[gi]) begin
                    pend_next[gi] = 1'b0;
                    ovf_next[gi]  = 1'b0;
                end else if (ack_hit[gi]) begin
                    pend_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Strict '>' keeps the lowest index on priority ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        win_vec   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (!win_found || (src_prio[i*PRIO_W +: PRIO_W] > win_prio))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_prio  = src_prio[i*PRIO_W +: PRIO_W];
                win_vec   = src_vec[i*VEC_W +: VEC_W];
            end
        end
        win_vec_ext              = '0;
        win_vec_ext[VEC_W-1:0]   = win_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q    <= '0;
            pend     <= '0;
            ovf      <= '0;
            state    <= IDLE;
            int_o    <= 1'b0;
            int_vec  <= '0;
            int_prio <= '0;
            int_src  <= '0;
        end else begin
            irq_q <= irq;
            pend  <= pend_next;
            ovf   <= ovf_next;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        int_src  <= win_idx;
                        int_prio <= win_prio;
                        int_vec  <= VEC_BASE | win_vec_ext;
                        int_o    <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (int_ack) begin
                        int_o <= 1'b0;
                        state <= RECOVER;
                    end else if (!elig[int_src]) begin
                        int_o <= 1'b0;
                        state <= IDLE;
                    end
                end
                RECOVER: begin
                    // One quiet cycle so control sees the updated PSR priority.
                    state <= IDLE;
                end
                default: begin
                    int_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Bench for lc3_int_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_lc3_int_ctrl;

    localparam int NS = 4;
    localparam int PW = 3;
    localparam int VW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   irq;
    logic [NS-1:0]   src_en;
    logic [NS*PW-1:0] src_prio;
    logic [NS*VW-1:0] src_vec;
    logic [PW-1:0]   psr_prio;
    logic            int_ack;
    logic            clr_en;
    logic [IW-1:0]   clr_idx;
    logic            int_o;
    logic [15:0]     int_vec;
    logic [PW-1:0]   int_prio;
    logic [IW-1:0]   int_src;
    logic [NS-1:0]   pend;
    logic [NS-1:0]   ovf;

    lc3_int_ctrl #(.NUM_SRC(NS), .PRIO_W(PW), .VEC_W(VW), .VEC_BASE(16'h0100)) dut (
        .clk(clk), .rst(rst), .irq(irq), .src_en(src_en), .src_prio(src_prio),
        .src_vec(src_vec), .psr_prio(psr_prio), .int_ack(int_ack), .clr_en(clr_en),
        .clr_idx(clr_idx), .int_o(int_o), .int_vec(int_vec), .int_prio(int_prio),
        .int_src(int_src), .pend(pend), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: per-source flags plus a handshake phase
    // (0 = idle, 1 = offering, 2 = one-cycle recovery).
    bit     m_irq_q [NS];
    bit     m_pend  [NS];
    bit     m_ovf   [NS];
    int     m_phase;
    bit     m_int_o;
    int     m_src, m_prio, m_vec;

    function automatic int prio_of(int i);
        return int'(src_prio[i*PW +: PW]);
    endfunction

    function automatic bit is_elig(int i);
        return m_pend[i] && src_en[i] && (prio_of(i) > int'(psr_prio));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_irq_q[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end
        m_phase = 0; m_int_o = 0; m_src = 0; m_prio = 0; m_vec = 0;
    endtask

    task automatic model_clock();
        bit n_pend [NS];
        bit n_ovf  [NS];
        bit el     [NS];
        int win;
        for (int i = 0; i < NS; i++) begin
            bit e, c, a;
            e = irq[i] && !m_irq_q[i];
            c = clr_en && (int'(clr_idx) == i);
            a = (m_phase == 1) && int_ack && (m_src == i);
            el[i] = is_elig(i);
            n_pend[i] = m_pend[i];
            n_ovf[i]  = m_ovf[i];
            if (e && (c || a))  n_pend[i] = 1;
            else if (e)         begin if (m_pend[i]) n_ovf[i] = 1; n_pend[i] = 1; end
            else if (c)         begin n_pend[i] = 0; n_ovf[i] = 0; end
            else if (a)         n_pend[i] = 0;
        end
        // Highest priority level first, then lowest index within that level.
        win = -1;
        for (int p = (1 << PW) - 1; p >= 0 && win < 0; p--)
            for (int i = 0; i < NS && win < 0; i++)
                if (el[i] && prio_of(i) == p) win = i;
        case (m_phase)
            0: if (win >= 0) begin
                m_phase = 1; m_int_o = 1; m_src = win; m_prio = prio_of(win);
                m_vec = 16'h0100 | int'(src_vec[win*VW +: VW]);
            end
            1: if (int_ack) begin m_phase = 2; m_int_o = 0; end
               else if (!el[m_src]) begin m_phase = 0; m_int_o = 0; end
            default: m_phase = 0;
        endcase
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = n_pend[i]; m_ovf[i] = n_ovf[i]; m_irq_q[i] = irq[i];
        end
    endtask

    function automatic logic [NS-1:0] pack(input bit v [NS]);
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic compare_all();
        check_val("int_o", 32'(int_o), 32'(m_int_o));
        check_val("pend", 32'(pend), 32'(pack(m_pend)));
        check_val("ovf", 32'(ovf), 32'(pack(m_ovf)));
        check_val("int_src", 32'(int_src), 32'(m_src));
        check_val("int_prio", 32'(int_prio), 32'(m_prio));
        check_val("int_vec", 32'(int_vec), 32'(m_vec));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_src(input int i, input int p, input logic [7:0] v);
        src_prio[i*PW +: PW] = PW'(p);
        src_vec[i*VW +: VW]  = v;
    endtask

    initial begin
        rst = 1'b0; irq = '0; src_en = '1; src_prio = '0; src_vec = '0;
        psr_prio = '0; int_ack = 1'b0; clr_en = 1'b0; clr_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_int_o", 32'(int_o), 32'd0);
        check_val("rst_pend", 32'(pend), 32'd0);
        check_val("rst_vec", 32'(int_vec), 32'd0);
        rst = 1'b1;
        step();

        // Single source: latency and vector formation.
        set_src(2, 5, 8'h80);
        irq = 4'b0100; step();
        check_val("t1_pend", 32'(pend), 32'h4);
        check_val("t1_int_o_early", 32'(int_o), 32'd0);
        irq = '0; step();
        check_val("t1_int_o", 32'(int_o), 32'd1);
        check_val("t1_vec", 32'(int_vec), 32'h0180);
        check_val("t1_prio", 32'(int_prio), 32'd5);
        check_val("t1_src", 32'(int_src), 32'd2);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check_val("t1_ack_pend", 32'(pend), 32'h0);
        check_val("t1_ack_int_o", 32'(int_o), 32'd0);
        step();

        // Two sources at once: higher priority first, then the other.
        set_src(1, 3, 8'h11); set_src(3, 6, 8'h33);
        irq = 4'b1010; step(); irq = '0; step();
        check_val("t2_first", 32'(int_src), 32'd3);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        step(); step();
        check_val("t2_second", 32'(int_src), 32'd1);
        check_val("t2_vec", 32'(int_vec), 32'h0111);

        // Withdrawal when PSR priority rises to the offered level.
        psr_prio = 3'd3; step(); step();
        check_val("t4_withdraw", 32'(int_o), 32'd0);
        check_val("t4_pend", 32'(pend[1]), 32'd1);
        clr_en = 1'b1; clr_idx = 2'd1; step(); clr_en = 1'b0; psr_prio = '0;

        // Equal priorities: lowest index wins; blocked when psr equals it.
        set_src(0, 4, 8'h00); set_src(1, 4, 8'h10);
        psr_prio = 3'd4; irq = 4'b0011; step(); irq = '0; step(); step();
        check_val("t3_blocked", 32'(int_o), 32'd0);
        psr_prio = 3'd0; step(); step();
        check_val("t3_tie", 32'(int_src), 32'd0);

        // Overflow, then ack coinciding with a new edge on the same source.
        set_src(2, 7, 8'h80);
        irq = 4'b0100; step(); irq = '0; step();
        irq = 4'b0100; step(); irq = '0;
        check_val("t5_ovf", 32'(ovf[2]), 32'd1);
        while (!(int_o && int_src == 2'd2) && m_phase != 3) begin
            int_ack = int_o; step(); int_ack = 1'b0;
            if (n_checks > 2000) break;
        end
        int_ack = 1'b1; irq = 4'b0100; step(); int_ack = 1'b0; irq = '0;
        check_val("t5_pend_kept", 32'(pend[2]), 32'd1);

        // Asynchronous reset while an interrupt is offered.
        step();
        rst = 1'b0; irq = 4'b1000; #1;
        model_reset();
        check_val("t6_int_o", 32'(int_o), 32'd0);
        check_val("t6_pend", 32'(pend), 32'd0);
        check_val("t6_ovf", 32'(ovf), 32'd0);
        @(negedge clk); rst = 1'b1;
        step();
        check_val("t6_repend", 32'(pend), 32'h8);
        irq = '0;

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(5) == 0) irq[i] = ~irq[i];
            if ($urandom_range(40) == 0) src_en = 4'($urandom);
            if ($urandom_range(30) == 0) psr_prio = 3'($urandom_range(3));
            if ($urandom_range(60) == 0) set_src($urandom_range(3), $urandom_range(7), 8'($urandom));
            int_ack = ($urandom_range(2) == 0);
            clr_en  = ($urandom_range(15) == 0);
            clr_idx = 2'($urandom);
            if ($urandom_range(400) == 0) begin
                rst = 1'b0; #1; model_reset();
                check_val("rnd_rst_int_o", 32'(int_o), 32'd0);
                @(negedge clk); rst = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
